// File: rtl/reduction_accumulator_v2.sv
// reduction_accumulator_v2: multi-tile row/column-sum or row-max reducer with saturating vector output
module reduction_accumulator_v2 #(
  parameter int TILE_SIZE = 4,
  parameter int IN_WIDTH = 32,
  parameter int ACC_WIDTH = 48,
  parameter int OUT_WIDTH = 32,
  parameter int MAX_TILES = 16,
  localparam int CW = $clog2(MAX_TILES + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  mode,
  input  logic [CW-1:0]               num_tiles,
  input  logic                        clear,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [IN_WIDTH-1:0]  mat_in [TILE_SIZE][TILE_SIZE],
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] vec_out [TILE_SIZE],
  output logic [TILE_SIZE-1:0]        sat_flag,
  output logic [CW-1:0]               tile_cnt
);
  typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;
  localparam logic signed [ACC_WIDTH-1:0] HI = {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] LO = ~HI;
  state_t state;
  logic [1:0] mode_q, md;
  logic [CW-1:0] tgt_q, tgt, cnt_nx;
  logic accept, done;
  logic signed [ACC_WIDTH-1:0] acc [TILE_SIZE];
  logic signed [ACC_WIDTH-1:0] red [TILE_SIZE];
  logic signed [ACC_WIDTH-1:0] acc_nx [TILE_SIZE];
  logic signed [ACC_WIDTH-1:0] rs, cs, rm, e;
  logic signed [OUT_WIDTH-1:0] sat_v [TILE_SIZE];
  logic [TILE_SIZE-1:0] sat_nx;
  assign in_ready = state != OUTPUT;
  assign accept = in_valid && in_ready && !clear;
  assign md = state == IDLE ? mode : mode_q;
  assign tgt = num_tiles == '0 ? CW'(1) : num_tiles > CW'(MAX_TILES) ? CW'(MAX_TILES) : num_tiles;
  assign cnt_nx = state == IDLE ? CW'(1) : tile_cnt + CW'(1);
  assign done = cnt_nx == (state == IDLE ? tgt : tgt_q);
  always_comb begin
    rs = '0;
    cs = '0;
    rm = '0;
    e = '0;
    for (int k = 0; k < TILE_SIZE; k++) begin
      rs = '0;
      cs = '0;
      rm = ACC_WIDTH'(mat_in[k][0]);
      for (int j = 0; j < TILE_SIZE; j++) begin
        e = ACC_WIDTH'(mat_in[k][j]);
        rs = rs + e;
        cs = cs + ACC_WIDTH'(mat_in[j][k]);
        rm = e > rm ? e : rm;
      end
      red[k] = md == 2'b10 ? rm : md == 2'b01 ? cs : rs;
      acc_nx[k] = state == IDLE ? red[k] : md == 2'b10 ? (red[k] > acc[k] ? red[k] : acc[k]) : acc[k] + red[k];
      sat_nx[k] = acc_nx[k] > HI || acc_nx[k] < LO;
      sat_v[k] = acc_nx[k] > HI ? HI[OUT_WIDTH-1:0] : acc_nx[k] < LO ? LO[OUT_WIDTH-1:0] : acc_nx[k][OUT_WIDTH-1:0];
    end
  end
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state <= IDLE;
      mode_q <= '0;
      tgt_q <= '0;
      tile_cnt <= '0;
      out_valid <= 1'b0;
      sat_flag <= '0;
      for (int k = 0; k < TILE_SIZE; k++) begin
        acc[k] <= '0;
        vec_out[k] <= '0;
      end
    end else if (accept) begin
      state <= done ? OUTPUT : ACCUM;
      tile_cnt <= cnt_nx;
      out_valid <= done;
      if (state == IDLE) begin
        mode_q <= mode;
        tgt_q <= tgt;
      end
      for (int k = 0; k < TILE_SIZE; k++) begin
        acc[k] <= acc_nx[k];
        if (done) vec_out[k] <= sat_v[k];
      end
      if (done) sat_flag <= sat_nx;
    end else if (state == OUTPUT && out_ready) begin
      state <= IDLE;
      tile_cnt <= '0;
      out_valid <= 1'b0;
      for (int k = 0; k < TILE_SIZE; k++) acc[k] <= '0;
    end
  end
endmodule
